// File: rtl/draw_pkg.sv
// Shared definitions for the draw scheduler: FSM encoding, client indices and
// pixel field widths, plus the "next enabled client" search used by the FSM.
package draw_pkg;
  localparam int NUM_CLIENTS = 4;
  localparam int X_W  = 9;
  localparam int Y_W  = 8;
  localparam int C_W  = 12;
  localparam int WD_W = 20;

  localparam logic [1:0] CL_BG    = 2'd0;
  localparam logic [1:0] CL_ITEMS = 2'd1;
  localparam logic [1:0] CL_HOOK  = 2'd2;
  localparam logic [1:0] CL_SCORE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_ADVANCE,
    ST_FRAME_DONE
  } state_t;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  // 'from' may be 4, meaning the search is exhausted.
  function automatic logic [2:0] pick_next(input logic [NUM_CLIENTS-1:0] mask,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(from))) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction
endpackage

// File: rtl/draw_pixel_mux.sv
// Registered pixel mux: forwards the granted client's pixel one cycle later.
// No backpressure; writes are only passed while the grant is live.
module draw_pixel_mux
  import draw_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 grant,
  input  logic                       grant_vld,
  input  logic [NUM_CLIENTS*X_W-1:0] cl_x,
  input  logic [NUM_CLIENTS*Y_W-1:0] cl_y,
  input  logic [NUM_CLIENTS*C_W-1:0] cl_color,
  input  logic [NUM_CLIENTS-1:0]     cl_we,
  output logic [X_W-1:0]             outX,
  output logic [Y_W-1:0]             outY,
  output logic [C_W-1:0]             color,
  output logic                       writeEn
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outX    <= '0;
      outY    <= '0;
      color   <= '0;
      writeEn <= 1'b0;
    end else begin
      outX    <= cl_x[X_W*int'(grant) +: X_W];
      outY    <= cl_y[Y_W*int'(grant) +: Y_W];
      color   <= cl_color[C_W*int'(grant) +: C_W];
      writeEn <= grant_vld & cl_we[grant];
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame-pass scheduler: starts each enabled client in order, waits for done or
// watchdog abort, and muxes the running client's pixels out with 1-cycle latency.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter logic [WD_W-1:0] TIMEOUT = 20'd200000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [NUM_CLIENTS-1:0]     client_mask,
  input  logic [NUM_CLIENTS*X_W-1:0] cl_x,
  input  logic [NUM_CLIENTS*Y_W-1:0] cl_y,
  input  logic [NUM_CLIENTS*C_W-1:0] cl_color,
  input  logic [NUM_CLIENTS-1:0]     cl_we,
  input  logic [NUM_CLIENTS-1:0]     cl_done,
  output logic [NUM_CLIENTS-1:0]     cl_enable,
  output logic [X_W-1:0]             outX,
  output logic [Y_W-1:0]             outY,
  output logic [C_W-1:0]             color,
  output logic                       writeEn,
  output logic                       busy,
  output logic                       frame_done,
  output logic [NUM_CLIENTS-1:0]     timeout_err,
  output logic [7:0]                 overrun_cnt
);

  state_t                 state;
  logic [NUM_CLIENTS-1:0] mask_q;
  logic [1:0]             idx;
  logic [WD_W-1:0]        wd;
  logic [2:0]             sel;

  // LATCH searches the live mask so unselected clients cost no cycles.
  assign sel = (state == ST_LATCH) ? pick_next(client_mask, {1'b0, CL_BG})
                                   : pick_next(mask_q, {1'b0, idx} + 3'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      idx         <= '0;
      wd          <= '0;
      cl_enable   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= '0;
      overrun_cnt <= '0;
    end else begin
      cl_enable  <= '0;
      frame_done <= 1'b0;
      if (frame_tick && busy && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state <= ST_LATCH;
            busy  <= 1'b1;
          end
        end
        ST_LATCH, ST_ADVANCE: begin
          if (state == ST_LATCH) begin
            mask_q <= client_mask;
            idx    <= CL_BG;
          end
          if (sel[2] && !(state == ST_ADVANCE && idx == CL_SCORE)) begin
            idx       <= sel[1:0];
            cl_enable <= 4'b0001 << sel[1:0];
            state     <= ST_START;
          end else begin
            frame_done <= 1'b1;
            state      <= ST_FRAME_DONE;
          end
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wd <= wd + 1'b1;
          // Done wins over a simultaneous watchdog expiry.
          if (cl_done[idx]) begin
            state <= ST_ADVANCE;
          end else if (wd == TIMEOUT - 1'b1) begin
            timeout_err[idx] <= 1'b1;
            state            <= ST_ADVANCE;
          end
        end
        ST_FRAME_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  draw_pixel_mux u_pixel_mux (
    .clock     (clock),
    .reset     (reset),
    .grant     (idx),
    .grant_vld (state == ST_WAIT),
    .cl_x      (cl_x),
    .cl_y      (cl_y),
    .cl_color  (cl_color),
    .cl_we     (cl_we),
    .outX      (outX),
    .outY      (outY),
    .color     (color),
    .writeEn   (writeEn)
  );

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with an enable-order and pixel scoreboard.
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  client_mask;
  logic [35:0] cl_x;
  logic [31:0] cl_y;
  logic [47:0] cl_color;
  logic [3:0]  cl_we;
  logic [3:0]  cl_done;
  logic [3:0]  cl_enable;
  logic [8:0]  outX;
  logic [7:0]  outY;
  logic [11:0] color;
  logic        writeEn;
  logic        busy;
  logic        frame_done;
  logic [3:0]  timeout_err;
  logic [7:0]  overrun_cnt;

  int tests = 0;
  int fails = 0;
  int exp_ovr = 0;
  logic [3:0] exp_err = '0;
  int exp_en_q[$];
  logic [28:0] pix_q[$];

  always #5 clock = ~clock;

  draw_scheduler #(.TIMEOUT(20'd16)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .client_mask (client_mask),
    .cl_x        (cl_x),
    .cl_y        (cl_y),
    .cl_color    (cl_color),
    .cl_we       (cl_we),
    .cl_done     (cl_done),
    .cl_enable   (cl_enable),
    .outX        (outX),
    .outY        (outY),
    .color       (color),
    .writeEn     (writeEn),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame pass, acting as the four clients. Called and returns just after a negedge.
  task automatic run_frame(input logic [3:0] mask, input int dly, input logic [3:0] hang,
                           input bit noise, input int n_ovr, input bit tick_at_done,
                           input logic [3:0] we);
    int exp_lat, cyc, rem, cur, nfd, fd_cyc, ovr_left;
    bit in_w, hanging;
    logic [3:0] own;
    exp_lat = 3;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        exp_en_q.push_back(k);
        exp_lat += 2 + (hang[k] ? TMO : dly);
      end
    end
    client_mask = mask;
    cl_we = we;
    frame_tick = 1'b1;
    cyc = 0; rem = 0; cur = 0; nfd = 0; fd_cyc = 0; hanging = 0; ovr_left = n_ovr;
    @(negedge clock);
    cyc = 1;
    while (cyc < 600 && !(nfd > 0 && cyc > fd_cyc + 8)) begin
      frame_tick = 1'b0;
      cl_done = '0;
      in_w = 0;
      if (writeEn) begin
        if (pix_q.size() == 0) check("pix_extra_write", 1, 0);
        else check("pix_value", {outX, outY, color}, pix_q.pop_front());
      end
      if (cl_enable != '0) begin
        check("enable_onehot", 32'($onehot(cl_enable)), 1);
        for (int k = 0; k < 4; k++) if (cl_enable[k]) cur = k;
        if (exp_en_q.size() == 0) check("enable_extra", cur, 32'hFF);
        else check("enable_order", cur, exp_en_q.pop_front());
        hanging = hang[cur];
        rem = hanging ? TMO : dly;
        if (noise) cl_done = 4'hF;
      end else if (rem > 0) begin
        in_w = 1;
        rem--;
        own = 4'b0001 << cur;
        if (rem == 0 && !hanging) cl_done = own;
        else if (noise) cl_done = 4'($urandom) & ~own;
      end
      if (in_w && cl_we[cur])
        pix_q.push_back({cl_x[9*cur +: 9], cl_y[8*cur +: 8], cl_color[12*cur +: 12]});
      if (frame_done) begin
        nfd++;
        if (nfd == 1) begin
          check("frame_latency", cyc + 1, exp_lat);
          fd_cyc = cyc;
          if (tick_at_done) begin
            frame_tick = 1'b1;
            exp_ovr++;
          end
        end
      end
      if (ovr_left > 0 && nfd == 0 && cyc >= 4 && (cyc % 2) == 0) begin
        frame_tick = 1'b1;
        ovr_left--;
        exp_ovr++;
      end
      @(negedge clock);
      cyc++;
    end
    cl_done = '0;
    cl_we = '0;
    frame_tick = 1'b0;
    check("frame_done_count", nfd, 1);
    check("enables_missing", exp_en_q.size(), 0);
    check("pix_missing", pix_q.size(), 0);
    check("busy_after_frame", busy, 0);
    check("overrun_cnt", overrun_cnt, exp_ovr);
    check("timeout_err", timeout_err, exp_err);
    exp_en_q.delete();
    pix_q.delete();
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    frame_tick = 1'b0;
    client_mask = '0;
    cl_x = {9'd300, 9'd200, 9'd100, 9'd7};
    cl_y = {8'd40, 8'd30, 8'd50, 8'd3};
    cl_color = {12'hDDD, 12'hCCC, 12'hBBB, 12'h123};
    cl_we = '0;
    cl_done = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {cl_enable, outX, outY, color, writeEn, busy, frame_done}, 0);
    check("reset_err_ovr", {timeout_err, overrun_cnt}, 0);
    reset = 1'b0;
    @(negedge clock);

    // All four clients, done 10 cycles after enable.
    run_frame(4'b1111, 10, 4'b0000, 0, 0, 0, 4'b0000);
    // Sparse mask with spurious done from non-granted clients and in START.
    run_frame(4'b0101, 3, 4'b0000, 1, 0, 0, 4'b0000);
    // Empty mask goes straight to frame_done.
    run_frame(4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    // Client 1 writes throughout; only its own WAIT window reaches the output.
    run_frame(4'b0011, 6, 4'b0000, 0, 0, 0, 4'b0001 << CL_ITEMS);
    // Client 2 hangs and is aborted; client 3 still runs.
    exp_err = 4'b0001 << CL_HOOK;
    run_frame(4'b1100, 5, 4'b0100, 0, 0, 0, 4'b0000);
    // Done on the same cycle the watchdog expires counts as done.
    run_frame(4'b0010, TMO, 4'b0000, 0, 0, 0, 4'b0000);
    // Three ticks during a busy pass.
    run_frame(4'b1111, 4, 4'b0000, 0, 3, 0, 4'b0000);
    // Tick in the FRAME_DONE cycle is an overrun, not a new pass.
    run_frame(4'b0001, 2, 4'b0000, 0, 0, 1, 4'b0000);

    // Asynchronous reset in the middle of client 2's WAIT.
    client_mask = 4'b1111;
    cl_we = 4'b0001 << CL_HOOK;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    cnt = 0;
    while (!cl_enable[CL_HOOK] && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_reached_client2", cl_enable, 4'b0100);
    repeat (3) @(negedge clock);
    check("pre_reset_write", writeEn, 1);
    check("pre_reset_err", timeout_err, 4'b0111 & ~(4'b0001 << CL_HOOK) & ~(4'b0001 << CL_SCORE) | exp_err);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {cl_enable, outX, outY, color, writeEn, busy, frame_done}, 0);
    check("async_reset_err_ovr", {timeout_err, overrun_cnt}, 0);
    @(negedge clock);
    reset = 1'b0;
    cl_we = '0;
    exp_err = '0;
    exp_ovr = 0;
    @(negedge clock);
    run_frame(4'b1111, 2, 4'b0000, 0, 0, 0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 20'd200000, maximum cycles a client may run before being aborted.
REQ-002 Parameter: NUM_CLIENTS, fixed at 4; clients are 0=background, 1=items, 2=hook, 3=score.
REQ-003 Port: clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: frame_tick  in  1  one-cycle pulse requesting a new frame pass.
REQ-006 Port: client_mask  in  4  bit k=1 means client k is drawn this frame; sampled at frame start.
REQ-007 Port: cl_x  in  36  client k X coordinate at bits [9k+8:9k].
REQ-008 Port: cl_y  in  32  client k Y coordinate at bits [8k+7:8k].
REQ-009 Port: cl_color  in  48  client k 12-bit colour at bits [12k+11:12k].
REQ-010 Port: cl_we  in  4  client k pixel write strobe.
REQ-011 Port: cl_done  in  4  client k completion pulse.
REQ-012 Port: cl_enable  out  4  one-hot, one-cycle start pulse to client k.
REQ-013 Port: outX / outY / color / writeEn  out  9 / 8 / 12 / 1  registered pixel stream to the VGA adapter.
REQ-014 Port: busy  out  1  high from frame start until FRAME_DONE completes.
REQ-015 Port: frame_done  out  1  one-cycle pulse at the end of each frame pass.
REQ-016 Port: timeout_err  out  4  sticky; bit k set when client k was aborted.
REQ-017 Port: overrun_cnt  out  8  count of frame_ticks that arrived while busy; saturates at 255.

Function
REQ-018 States: IDLE, LATCH, START, WAIT, ADVANCE, FRAME_DONE.
REQ-019 IDLE: on frame_tick, go to LATCH.
REQ-020 LATCH: capture client_mask into mask_q, set idx=0, go to ADVANCE-check (select the lowest set bit).
REQ-021 Client selection: clients with mask_q bit 0 are skipped with zero cycles spent on them; if no bits remain, go to FRAME_DONE.
REQ-022 START: assert cl_enable[idx] for exactly one cycle, clear the watchdog, go to WAIT.
REQ-023 WAIT: grant=idx; on cl_done[idx], go to ADVANCE; if the watchdog reaches TIMEOUT-1 first, set timeout_err[idx] and go to ADVANCE.
REQ-024 ADVANCE: move to the next higher set bit of mask_q, then START; after client 3, go to FRAME_DONE.
REQ-025 FRAME_DONE: pulse frame_done for 1 cycle, then IDLE.
REQ-026 Pixel path, 1-cycle latency: outX/outY/color follow the granted client; writeEn=cl_we[grant] only in WAIT, otherwise 0.
REQ-027 In WAIT, cl_we of non-granted clients has no effect.
REQ-028 cl_done of a non-granted client is ignored.
REQ-029 A cl_done[idx] arriving in the same cycle as the timeout is treated as done, and no error bit is set.
REQ-030 frame_tick while busy does not restart the pass and increments overrun_cnt.
REQ-031 frame_tick in the FRAME_DONE cycle counts as an overrun.
REQ-032 Watchdog width is 20 bits; it is cleared in START and increments every WAIT cycle.
REQ-033 A client with done asserted in the same cycle as its enable is not accepted; done is sampled only in WAIT.
REQ-034 Frame latency, all clients responding: 2 + sum over enabled clients of (1 + cycles to done + 1) + 1 cycles from frame_tick to frame_done.

Reset
REQ-035 Reset takes effect asynchronously, at any time including mid-client, and forces state IDLE.
REQ-036 Reset clears to 0: all outputs, timeout_err, overrun_cnt, mask_q, idx, and the watchdog.
REQ-037 The first frame_tick accepted after reset deasserts starts a normal pass.

Structure
REQ-038 Shared package draw_pkg holds: the state encoding, client index constants (CL_BG, CL_ITEMS, CL_HOOK, CL_SCORE), and the coordinate and colour widths (9/8/12).
REQ-039 One sub-module, draw_pixel_mux, contains the registered, grant-selected pixel mux; the FSM, watchdog and counters stay in draw_scheduler.

Verification
REQ-040 Mask 4'b1111, each client done 10 cycles after enable -> enables fire in order 0,1,2,3; frame_done follows; timeout_err=0.
REQ-041 Mask 4'b0101 -> only cl_enable[0] and cl_enable[2] pulse; clients 1 and 3 cost no cycles.
REQ-042 Client 2 never asserts done, TIMEOUT=16 -> abort after 16 WAIT cycles; timeout_err=4'b0100; client 3 still runs.
REQ-043 Client 1 asserts we with X=100, Y=50, colour 12'hBBB while client 0 is granted -> writeEn stays 0; once client 1 is granted, the same inputs appear on the outputs 1 cycle later.
REQ-044 Three frame_ticks during a busy pass -> overrun_cnt=3 and a single frame_done.
REQ-045 Reset asserted mid-WAIT of client 2 -> outputs are 0 immediately, without waiting for a clock edge; state is IDLE; the next frame_tick restarts at client 0.
